// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side packer: FSM encodings,
// default lane width and a constant-function log2 for counter sizing.
package fifo_pkg;

    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;

    typedef enum logic [1:0] {
        ST_FILL  = FILL,
        ST_DRAIN = DRAIN
    } rd_state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to hold values 0 .. value-1 (at least 1).
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_acc.sv
// Lane accumulator: tracks the pop in flight, drops landing data into
// lane[lane_cnt] and exposes a merged view that already includes a lane
// landing this cycle, so the top can emit on the same edge it lands.
module fifo_rd_packer_acc
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int PACK  = 4,
    parameter int CW    = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    input  logic [WIDTH-1:0]       rdata_i,
    output logic [WIDTH*PACK-1:0]  lanes_o,
    output logic [CW-1:0]          lane_cnt_o,
    output logic                   inflight_o
);

    logic          inflight_reg;
    logic [CW-1:0] lane_cnt_reg;

    // A pop issued this cycle returns data on the next one.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= pop_i;
        end
    end

    // Lane count: an emit takes every buffered lane, including one landing now.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lane_cnt_reg <= '0;
        end else if (clear_i) begin
            lane_cnt_reg <= '0;
        end else if (inflight_reg) begin
            lane_cnt_reg <= lane_cnt_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
            logic [WIDTH-1:0] lane_reg;
            logic             land_here;

            assign land_here = inflight_reg && (lane_cnt_reg == CW'(gi));

            // Capture landing data into this lane when it is the next free slot.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    lane_reg <= '0;
                end else if (land_here) begin
                    lane_reg <= rdata_i;
                end
            end

            assign lanes_o[gi*WIDTH +: WIDTH] = land_here ? rdata_i : lane_reg;
        end
    endgenerate

    assign lane_cnt_o = lane_cnt_reg;
    assign inflight_o = inflight_reg;

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: packs PACK lanes of WIDTH bits into one word
// on a valid/ready stream, emitting partial words (with keep mask) on an
// idle timeout or on flush_i. Never pops an empty FIFO.
// Optional: define FIFO_RD_PACKER_PARITY_EN to add m_par_o (per-lane even
// parity, registered with m_data_o, zero for unkept lanes).
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int PACK    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    output logic                   rd_en_o,
    input  logic [WIDTH-1:0]       rdata_i,
    input  logic                   empty_i,
    input  logic                   flush_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [WIDTH*PACK-1:0]  m_data_o,
    output logic [PACK-1:0]        m_keep_o
`ifdef FIFO_RD_PACKER_PARITY_EN
    ,
    output logic [PACK-1:0]        m_par_o
`endif
);

    localparam int CW = clog2(PACK + 1);
    localparam int IW = clog2(TIMEOUT + 1);

    logic [WIDTH*PACK-1:0] lanes;
    logic [CW-1:0]         lane_cnt;
    logic                  inflight;
    logic [CW-1:0]         cnt_eff;

    rd_state_t             state_reg, state_next;
    logic [IW-1:0]         idle_cnt_reg;
    logic                  m_valid_reg;
    logic [WIDTH*PACK-1:0] m_data_reg;
    logic [PACK-1:0]       m_keep_reg;

    logic                  flush_pend;
    logic                  out_free;
    logic                  timed_out;
    logic                  emit_full;
    logic                  emit_part;
    logic                  emit;
    logic [WIDTH*PACK-1:0] data_next;
    logic [PACK-1:0]       keep_next;
    logic [PACK-1:0]       par_next;

    fifo_rd_packer_acc #(
        .WIDTH (WIDTH),
        .PACK  (PACK),
        .CW    (CW)
    ) u_acc (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .pop_i      (rd_en_o),
        .clear_i    (emit),
        .rdata_i    (rdata_i),
        .lanes_o    (lanes),
        .lane_cnt_o (lane_cnt),
        .inflight_o (inflight)
    );

    // Lanes held plus the one landing this cycle.
    assign cnt_eff    = lane_cnt + CW'(inflight);
    assign flush_pend = (state_reg == ST_DRAIN);
    assign out_free   = !m_valid_reg || m_ready_i;
    assign timed_out  = (idle_cnt_reg == IW'(TIMEOUT));
    assign emit_full  = out_free && (cnt_eff == CW'(PACK));
    assign emit_part  = out_free && (flush_pend || timed_out) && (lane_cnt != '0) && !inflight;
    assign emit       = emit_full || emit_part;

    // Pop only when space remains for the returning lane; reset holds it low.
    assign rd_en_o = rst_n_i && !empty_i && !flush_pend && (cnt_eff < CW'(PACK));

    generate
        for (genvar gi = 0; gi < PACK; gi++) begin : g_out
            assign keep_next[gi]                = (CW'(gi) < cnt_eff);
            assign data_next[gi*WIDTH +: WIDTH] = keep_next[gi] ? lanes[gi*WIDTH +: WIDTH] : '0;
            assign par_next[gi]                 = keep_next[gi] & (^lanes[gi*WIDTH +: WIDTH]);
        end
    endgenerate

    // FSM state register; DRAIN doubles as the flush-pending flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= ST_FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: a flush with data buffered parks in DRAIN until the emit.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FILL: begin
                if (flush_i && (cnt_eff != '0) && !emit) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (emit || (cnt_eff == '0)) begin
                    state_next = ST_FILL;
                end
            end
            default: state_next = ST_FILL;
        endcase
    end

    // Idle counter: runs only with a settled partial word, saturates at TIMEOUT.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idle_cnt_reg <= '0;
        end else if (emit || inflight) begin
            idle_cnt_reg <= '0;
        end else if ((lane_cnt != '0) && !timed_out) begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
    end

    // Output register: load on emit, drop valid once accepted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_keep_reg  <= '0;
        end else if (emit) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= data_next;
            m_keep_reg  <= keep_next;
        end else if (m_ready_i) begin
            m_valid_reg <= 1'b0;
        end
    end

    assign m_valid_o = m_valid_reg;
    assign m_data_o  = m_data_reg;
    assign m_keep_o  = m_keep_reg;

`ifdef FIFO_RD_PACKER_PARITY_EN
    logic [PACK-1:0] m_par_reg;

    // Parity travels with the data word.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_par_reg <= '0;
        end else if (emit) begin
            m_par_reg <= par_next;
        end
    end

    assign m_par_o = m_par_reg;
`else
    logic unused_par;
    assign unused_par = ^par_next;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a behavioural FIFO feeds the DUT,
// stimulus pushes expected words into a queue, and a negedge monitor
// pops and compares every accepted word.
module tb_fifo_rd_packer;

    localparam int WIDTH   = 8;
    localparam int PACK    = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en;
    logic [7:0]  rdata = 8'h00;
    logic        empty;
    logic        flush = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
`ifdef FIFO_RD_PACKER_PARITY_EN
    logic [3:0]  m_par;
`endif

    always #5 clk = ~clk;

    fifo_rd_packer #(
        .WIDTH   (WIDTH),
        .PACK    (PACK),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .rd_en_o   (rd_en),
        .rdata_i   (rdata),
        .empty_i   (empty),
        .flush_i   (flush),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_data_o  (m_data),
        .m_keep_o  (m_keep)
`ifdef FIFO_RD_PACKER_PARITY_EN
        ,
        .m_par_o   (m_par)
`endif
    );

    // Behavioural FIFO: read data valid the cycle after a pop.
    logic [7:0] fifo_mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    assign empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rd_en && (wr_ptr != rd_ptr)) begin
            rdata  <= fifo_mem[rd_ptr % 256];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic [3:0]  par;
        int          at_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails = 0;
    int   n_words = 0;
    int   expired_events = 0;
    int   expired_seen = 0;
    bit   chk_rden_low = 1'b0;

    function automatic logic [3:0] lane_parity(input logic [31:0] d, input logic [3:0] k);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i] = k[i] & (^d[8*i +: 8]);
        end
        return p;
    endfunction

    task automatic push_fifo(input logic [7:0] v);
        fifo_mem[wr_ptr % 256] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k,
                               input logic [3:0] p, input int c);
        exp_t e;
        e.data = d;
        e.keep = k;
        e.par = p;
        e.at_cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            expired_events = expired_events + 1;
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    // Monitor: all comparisons, sampled on the falling edge.
    exp_t        cur;
    bit          stall = 1'b0;
    logic [31:0] hold_data;
    logic [3:0]  hold_keep;

    always @(negedge clk) begin
        if (!rst_n) begin
            n_checks++;
            if (m_valid || (m_keep != 4'h0) || (m_data != 32'h0) || rd_en) begin
                n_fails++;
                $display("FAIL reset_outputs: valid=%0b keep=%h data=%h rd_en=%0b, required all 0",
                         m_valid, m_keep, m_data, rd_en);
            end
            stall = 1'b0;
        end else begin
            if (empty) begin
                n_checks++;
                if (rd_en) begin
                    n_fails++;
                    $display("FAIL pop_on_empty: rd_en=1 while empty=1 at cyc %0d, required 0", cyc);
                end
            end
            if (chk_rden_low) begin
                n_checks++;
                if (rd_en) begin
                    n_fails++;
                    $display("FAIL rd_en_full_acc: rd_en=1 at cyc %0d, required 0", cyc);
                end
            end
            if (stall) begin
                n_checks++;
                if (!m_valid || (m_data != hold_data) || (m_keep != hold_keep)) begin
                    n_fails++;
                    $display("FAIL stall_stable: valid=%0b data=%h keep=%h, required 1 %h %h",
                             m_valid, m_data, m_keep, hold_data, hold_keep);
                end
            end
            if (m_valid && m_ready) begin
                n_words++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_word: data=%h keep=%h, required no word", m_data, m_keep);
                end else begin
                    cur = exp_q.pop_front();
                    $display("word %0d: data=%h keep=%h par=%h cyc=%0d", n_words, m_data, m_keep, cur.par, cyc);
                    n_checks++;
                    if (m_data != cur.data) begin
                        n_fails++;
                        $display("FAIL word_data: got %h, required %h", m_data, cur.data);
                    end
                    n_checks++;
                    if (m_keep != cur.keep) begin
                        n_fails++;
                        $display("FAIL word_keep: got %h, required %h", m_keep, cur.keep);
                    end
                    if (cur.at_cyc >= 0) begin
                        n_checks++;
                        if (cyc != cur.at_cyc) begin
                            n_fails++;
                            $display("FAIL word_timing: at cyc %0d, required %0d", cyc, cur.at_cyc);
                        end
                    end
`ifdef FIFO_RD_PACKER_PARITY_EN
                    n_checks++;
                    if (m_par != cur.par) begin
                        n_fails++;
                        $display("FAIL word_parity: got %b, required %b", m_par, cur.par);
                    end
`endif
                end
            end
            stall = m_valid && !m_ready;
            hold_data = m_data;
            hold_keep = m_keep;
        end
        if (expired_events != expired_seen) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain_timeout: %0d words still expected, required 0", expired_events - expired_seen);
            expired_seen = expired_events;
        end
    end

    int c0;

    initial begin
        // 1: full words after reset, one per PACK+1 cycles.
        for (int i = 0; i < 8; i++) push_fifo(8'h11 + 8'(i));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        c0 = cyc;
        expect_word(32'h14131211, 4'hF, lane_parity(32'h14131211, 4'hF), c0 + 5);
        expect_word(32'h18171615, 4'hF, lane_parity(32'h18171615, 4'hF), c0 + 10);
        wait_drain(100);

        // 2: two lanes then idle timeout.
        @(posedge clk);
        #1;
        c0 = cyc;
        push_fifo(8'hA1);
        push_fifo(8'hA2);
        expect_word(32'h0000A2A1, 4'h3, lane_parity(32'h0000A2A1, 4'h3), c0 + 20);
        wait_drain(100);

        // 3: flush while the only pop is in flight.
        @(posedge clk);
        #1;
        c0 = cyc;
        push_fifo(8'h5C);
        expect_word(32'h0000005C, 4'h1, lane_parity(32'h0000005C, 4'h1), c0 + 3);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_drain(100);

        // 4: downstream stalled for 20 cycles.
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_fifo(8'h21 + 8'(i));
        expect_word(32'h24232221, 4'hF, lane_parity(32'h24232221, 4'hF), -1);
        expect_word(32'h28272625, 4'hF, lane_parity(32'h28272625, 4'hF), -1);
        expect_word(32'h2C2B2A29, 4'hF, lane_parity(32'h2C2B2A29, 4'hF), -1);
        repeat (12) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) push_fifo(8'h29 + 8'(i));
        chk_rden_low = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk_rden_low = 1'b0;
        m_ready = 1'b1;
        wait_drain(100);

        // 5: reset with two lanes landed and one in flight.
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) push_fifo(8'h31 + 8'(i));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_word(32'h37363534, 4'hF, lane_parity(32'h37363534, 4'hF), -1);
        expect_word(32'h00000038, 4'h1, lane_parity(32'h00000038, 4'h1), -1);
        wait_drain(100);

        // 6: parity pattern.
        @(posedge clk);
        #1;
        push_fifo(8'h00);
        push_fifo(8'h07);
        push_fifo(8'h03);
        push_fifo(8'h01);
        expect_word(32'h01030700, 4'hF, 4'b1010, -1);
        wait_drain(100);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
